controlador_ula: RTL

- Control unit that sequences one ULA instruction at a time.
- Drives the 2-bit `controle` codes of the X operand register and the Y accumulator register, plus the ULA operation select.
- Accepts an opcode with a start pulse and steps through load, execute, write-back and iterative-shift states.
- Returns a one-cycle done pulse when the instruction completes.
- Sits between the instruction source (switches/top level) and the register/ULA datapath.

---
 rtl/ula_pkg.sv | 90 +++++++++
 rtl/controlador_ula.sv | 75 +++++++
 2 files changed

// File: rtl/ula_pkg.sv
// Shared encodings for the ULA datapath: register control codes, opcodes,
// ULA select codes and the sequencer state, plus the sequencer output decode.
package ula_pkg;

    localparam logic [1:0] CTRL_CLEAR   = 2'd0;
    localparam logic [1:0] CTRL_LOAD    = 2'd1;
    localparam logic [1:0] CTRL_HOLD    = 2'd2;
    localparam logic [1:0] CTRL_DESLOCA = 2'd3;

    localparam logic [2:0] OP_CLR = 3'd0;
    localparam logic [2:0] OP_LDY = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    localparam logic [2:0] ULA_ADD   = 3'd0;
    localparam logic [2:0] ULA_SUB   = 3'd1;
    localparam logic [2:0] ULA_AND   = 3'd2;
    localparam logic [2:0] ULA_OR    = 3'd3;
    localparam logic [2:0] ULA_PASSA = 3'd4;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CARREGA_X = 3'd1,
        ESCREVE_Y = 3'd2,
        LIMPA_Y   = 3'd3,
        DESLOCA   = 3'd4,
        FIM       = 3'd5
    } estado_t;

    typedef struct packed {
        logic [1:0] controle_x;
        logic [1:0] controle_y;
        logic [2:0] sel_ula;
        logic       ocupado;
        logic       pronto;
    } saidas_t;

    // First state entered when an instruction is accepted.
    function automatic estado_t destino(input logic [2:0] op);
        estado_t e;
        case (op)
            OP_CLR:  e = LIMPA_Y;
            OP_SHL:  e = DESLOCA;
            OP_NOP:  e = FIM;
            default: e = CARREGA_X;
        endcase
        return e;
    endfunction

    // Only LDY and the ALU opcodes reach ESCREVE_Y; LDY passes X straight through.
    function automatic logic [2:0] sel_de(input logic [2:0] op);
        logic [2:0] s;
        case (op)
            OP_ADD:  s = ULA_ADD;
            OP_SUB:  s = ULA_SUB;
            OP_AND:  s = ULA_AND;
            OP_OR:   s = ULA_OR;
            default: s = ULA_PASSA;
        endcase
        return s;
    endfunction

    // Moore output pattern for a state; op only matters in ESCREVE_Y.
    function automatic saidas_t decodifica(input estado_t e, input logic [2:0] op);
        saidas_t s;
        s.controle_x = CTRL_HOLD;
        s.controle_y = CTRL_HOLD;
        s.sel_ula    = 3'd0;
        s.ocupado    = 1'b1;
        s.pronto     = 1'b0;
        case (e)
            OCIOSO:    s.ocupado    = 1'b0;
            CARREGA_X: s.controle_x = CTRL_LOAD;
            ESCREVE_Y: begin
                s.controle_y = CTRL_LOAD;
                s.sel_ula    = sel_de(op);
            end
            LIMPA_Y:   s.controle_y = CTRL_CLEAR;
            DESLOCA:   s.controle_y = CTRL_DESLOCA;
            FIM:       s.pronto     = 1'b1;
            default:   s.ocupado    = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controlador_ula.sv
// Sequencer for one ULA instruction at a time: drives regX/regY control codes
// and the ULA select, and pulses pronto when the instruction completes.
module controlador_ula
    import ula_pkg::*;
#(
    parameter int LARGURA_CONT = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    inicio,
    input  logic [2:0]              instrucao,
    input  logic [LARGURA_CONT-1:0] quantidade,
    output logic [1:0]              controle_x,
    output logic [1:0]              controle_y,
    output logic [2:0]              sel_ula,
    output logic                    ocupado,
    output logic                    pronto
);

    localparam logic [LARGURA_CONT-1:0] UM = LARGURA_CONT'(1);

    estado_t                 estado;
    logic [2:0]              opcode;
    logic [LARGURA_CONT-1:0] contador;
    saidas_t                 saida;

    // Outputs are registered alongside the state: each transition loads the
    // pattern of the state being entered, so they stay a pure function of state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= OCIOSO;
            opcode   <= '0;
            contador <= '0;
            saida    <= decodifica(OCIOSO, OP_CLR);
        end else begin
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        opcode   <= instrucao;
                        contador <= quantidade;
                        estado   <= destino(instrucao);
                        saida    <= decodifica(destino(instrucao), instrucao);
                    end
                end
                CARREGA_X: begin
                    estado <= ESCREVE_Y;
                    saida  <= decodifica(ESCREVE_Y, opcode);
                end
                ESCREVE_Y, LIMPA_Y: begin
                    estado <= FIM;
                    saida  <= decodifica(FIM, opcode);
                end
                DESLOCA: begin
                    if (contador == '0) begin
                        estado <= FIM;
                        saida  <= decodifica(FIM, opcode);
                    end else begin
                        contador <= contador - UM;
                    end
                end
                default: begin
                    estado <= OCIOSO;
                    saida  <= decodifica(OCIOSO, opcode);
                end
            endcase
        end
    end

    assign controle_x = saida.controle_x;
    assign controle_y = saida.controle_y;
    assign sel_ula    = saida.sel_ula;
    assign ocupado    = saida.ocupado;
    assign pronto     = saida.pronto;

endmodule
